xbus_arbiter: RTL and testbench

Two-master arbiter and address decoder for the peripheral bus (xbus). It shares one xbus between the CPU load/store port (m0) and the debug/loader port (m1) using round-robin arbitration. It decodes each granted address into a one-hot chip select for up to NSLV peripherals (LED/switch, UART, timer, ...), then returns registered read data and a completion strobe to the owning master.

---
 rtl/xbus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_xbus_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xbus_arbiter.sv
// Two-master round-robin arbiter and slot decoder for the xbus.
// One transaction per three cycles: grant (IDLE), select (ACCESS), respond (RESP).
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif

module xbus_arbiter #(
  parameter int unsigned NSLV    = 4,
  parameter int unsigned SEL_LSB = 4,
  parameter int unsigned BASE    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [`XBYTEC-1:0]       m0_be,
  input  logic [`XADDRW-1:0]       m0_addr,
  input  logic [`XDATAW-1:0]       m0_wdata,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [`XDATAW-1:0]       m0_rdata,
  output logic                     m0_err,

  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [`XBYTEC-1:0]       m1_be,
  input  logic [`XADDRW-1:0]       m1_addr,
  input  logic [`XDATAW-1:0]       m1_wdata,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [`XDATAW-1:0]       m1_rdata,
  output logic                     m1_err,

  output logic [NSLV-1:0]          xbus_cs,
  output logic                     xbus_we,
  output logic [`XBYTEC-1:0]       xbus_be,
  output logic [`XADDRW-1:0]       xbus_addr,
  output logic [`XDATAW-1:0]       xbus_wdata,
  input  logic [NSLV*`XDATAW-1:0]  xbus_rdata
);

  localparam int unsigned SELW    = $clog2(NSLV);
  localparam int unsigned TAG_LSB = SEL_LSB + SELW;
  localparam int unsigned TAGW    = `XADDRW - TAG_LSB;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 owner_q;
  logic                 we_q;
  logic [`XBYTEC-1:0]   be_q;
  logic [`XADDRW-1:0]   addr_q;
  logic [`XDATAW-1:0]   wdata_q;
  logic [`XDATAW-1:0]   rdata0_q, rdata1_q;
  logic                 err0_q, err1_q;

  logic                 any_req;
  logic                 win;
  logic [SELW-1:0]      slot;
  logic [TAGW-1:0]      tag;
  logic                 hit;
  logic [`XDATAW-1:0]   slot_rdata;
  logic [`XDATAW-1:0]   resp_data;

  assign any_req = m0_req | m1_req;
  // On a tie the master not granted last wins; a lone requester always wins.
  assign win     = (m0_req && m1_req) ? ~last_q : m1_req;

  assign slot = addr_q[SEL_LSB +: SELW];
  assign tag  = addr_q[`XADDRW-1:TAG_LSB];
  assign hit  = (tag == TAGW'(BASE));

  always_comb begin
    slot_rdata = '0;
    for (int unsigned s = 0; s < NSLV; s++) begin
      if (slot == SELW'(s)) slot_rdata = xbus_rdata[s*`XDATAW +: `XDATAW];
    end
  end

  assign resp_data = (hit && !we_q) ? slot_rdata : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          last_d  = win;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    xbus_cs   = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          m0_gnt = ~win;
          m1_gnt = win;
        end
      end
      ACCESS: begin
        if (hit) xbus_cs[slot] = 1'b1;
      end
      RESP: begin
        m0_rvalid = ~owner_q;
        m1_rvalid = owner_q;
      end
      default: ;
    endcase
  end

  // Transaction latches and per-master response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && any_req) begin
        owner_q <= win;
        we_q    <= win ? m1_we    : m0_we;
        be_q    <= win ? m1_be    : m0_be;
        addr_q  <= win ? m1_addr  : m0_addr;
        wdata_q <= win ? m1_wdata : m0_wdata;
      end
      // Each master keeps its own copy so its rdata holds until its next response.
      if (state_q == ACCESS) begin
        if (owner_q) begin
          rdata1_q <= resp_data;
          err1_q   <= ~hit;
        end else begin
          rdata0_q <= resp_data;
          err0_q   <= ~hit;
        end
      end
    end
  end

  assign xbus_we    = we_q;
  assign xbus_be    = be_q;
  assign xbus_addr  = addr_q;
  assign xbus_wdata = wdata_q;

  assign m0_rdata = rdata0_q;
  assign m0_err   = err0_q;
  assign m1_rdata = rdata1_q;
  assign m1_err   = err1_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter: vector table plus reset and tie sequences.
`timescale 1ns/1ps

module tb_xbus_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m0_req, m0_we, m1_req, m1_we;
  logic [3:0]   m0_be, m1_be;
  logic [31:0]  m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic         m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]  m0_rdata, m1_rdata;
  logic [3:0]   xbus_cs;
  logic         xbus_we;
  logic [3:0]   xbus_be;
  logic [31:0]  xbus_addr, xbus_wdata;
  logic [127:0] xbus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Slot s returns 0x00A5_0s03
  assign xbus_rdata = {32'h00A5_0303, 32'h00A5_0203, 32'h00A5_0103, 32'h00A5_0003};

  xbus_arbiter #(.NSLV(4), .SEL_LSB(4), .BASE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .xbus_cs(xbus_cs), .xbus_we(xbus_we), .xbus_be(xbus_be), .xbus_addr(xbus_addr),
    .xbus_wdata(xbus_wdata), .xbus_rdata(xbus_rdata)
  );

  typedef struct {
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic        g0;
    logic        g1;
    logic        rv0;
    logic        rv1;
    logic [3:0]  cs;
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0;
  endtask

  // Leaves the bench 1ns after the first edge with rst_n released.
  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    m0_be = 4'hF; m0_wdata = 32'hDEAD_BEEF;
    m1_be = 4'h1; m1_wdata = 32'h0000_005A;

    //                m0r we addr          m1r we addr          g0 g1 rv0 rv1 cs    we err rdata
    vecs[0]  = '{1'b1,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b1,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,32'h0};
    vecs[1]  = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b0,4'h1,1'b0,1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b1,1'b0,4'h0,1'b0,1'b0,32'h00A5_0003};
    vecs[3]  = '{1'b0,1'b0,32'h000, 1'b1,1'b1,32'h014, 1'b0,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,32'h0};
    vecs[4]  = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b0,4'h2,1'b1,1'b0,32'h0};
    vecs[5]  = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b1,4'h0,1'b0,1'b0,32'h0};
    vecs[6]  = '{1'b1,1'b0,32'h100, 1'b0,1'b0,32'h000, 1'b1,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,32'h0};
    vecs[7]  = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,32'h0};
    vecs[8]  = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b1,1'b0,4'h0,1'b0,1'b1,32'h0};
    // Tie with last = m0, so m1 wins; m0 keeps requesting
    vecs[9]  = '{1'b1,1'b0,32'h020, 1'b1,1'b0,32'h030, 1'b0,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,32'h0};
    vecs[10] = '{1'b1,1'b0,32'h020, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b0,4'h8,1'b0,1'b0,32'h0};
    vecs[11] = '{1'b1,1'b0,32'h020, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b1,4'h0,1'b0,1'b0,32'h00A5_0303};
    vecs[12] = '{1'b1,1'b0,32'h020, 1'b0,1'b0,32'h000, 1'b1,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,32'h0};
    vecs[13] = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b0,4'h4,1'b0,1'b0,32'h0};
    // m1 raises req during m0's RESP: no grant until the IDLE cycle after
    vecs[14] = '{1'b0,1'b0,32'h000, 1'b1,1'b0,32'h030, 1'b0,1'b0,1'b1,1'b0,4'h0,1'b0,1'b0,32'h00A5_0203};
    vecs[15] = '{1'b0,1'b0,32'h000, 1'b1,1'b0,32'h030, 1'b0,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,32'h0};
    vecs[16] = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b0,4'h8,1'b0,1'b0,32'h0};
    vecs[17] = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b1,4'h0,1'b0,1'b0,32'h00A5_0303};
    vecs[18] = '{1'b0,1'b0,32'h000, 1'b0,1'b0,32'h000, 1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,1'b0,32'h0};

    // Reset values
    do_reset();
    #4;
    chk("rst_gnt",    {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_err",    {30'd0, m1_err, m0_err}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_cs",     {28'd0, xbus_cs}, 32'd0);
    chk("rst_xattr",  {27'd0, xbus_we, xbus_be}, 32'd0);
    chk("rst_xaddr",  xbus_addr, 32'd0);
    chk("rst_xwdata", xbus_wdata, 32'd0);

    // Table: one row per cycle, driven 1ns after the edge, sampled at the falling edge
    for (int unsigned i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we; m0_addr = vecs[i].m0_addr;
      m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we; m1_addr = vecs[i].m1_addr;
      #4;
      chk($sformatf("v%0d_gnt0", i), {31'd0, m0_gnt}, {31'd0, vecs[i].g0});
      chk($sformatf("v%0d_gnt1", i), {31'd0, m1_gnt}, {31'd0, vecs[i].g1});
      chk($sformatf("v%0d_rv0", i),  {31'd0, m0_rvalid}, {31'd0, vecs[i].rv0});
      chk($sformatf("v%0d_rv1", i),  {31'd0, m1_rvalid}, {31'd0, vecs[i].rv1});
      chk($sformatf("v%0d_cs", i),   {28'd0, xbus_cs}, {28'd0, vecs[i].cs});
      if (vecs[i].cs != 4'h0) begin
        chk($sformatf("v%0d_xwe", i), {31'd0, xbus_we}, {31'd0, vecs[i].we});
        if (vecs[i].we) begin
          chk($sformatf("v%0d_xbe", i),    {28'd0, xbus_be}, 32'h1);
          chk($sformatf("v%0d_xaddr", i),  xbus_addr, 32'h14);
          chk($sformatf("v%0d_xwdata", i), xbus_wdata, 32'h5A);
        end
      end
      if (vecs[i].rv0) begin
        chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].rdata);
        chk($sformatf("v%0d_m0_err", i),   {31'd0, m0_err}, {31'd0, vecs[i].err});
      end
      if (vecs[i].rv1) begin
        chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].rdata);
        chk($sformatf("v%0d_m1_err", i),   {31'd0, m1_err}, {31'd0, vecs[i].err});
      end
    end

    // Continuous tie out of reset: m0, m1, m0, m1 at cycles 0, 3, 6, 9
    do_reset();
    for (int unsigned c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h00;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
      #4;
      chk($sformatf("tie%0d_gnt0", c), {31'd0, m0_gnt},    {31'd0, (c % 6) == 0});
      chk($sformatf("tie%0d_gnt1", c), {31'd0, m1_gnt},    {31'd0, (c % 6) == 3});
      chk($sformatf("tie%0d_rv0", c),  {31'd0, m0_rvalid}, {31'd0, (c % 6) == 2});
      chk($sformatf("tie%0d_rv1", c),  {31'd0, m1_rvalid}, {31'd0, (c % 6) == 5});
      if ((c % 6) == 2) chk($sformatf("tie%0d_m0_rdata", c), m0_rdata, 32'h00A5_0003);
      if ((c % 6) == 5) chk($sformatf("tie%0d_m1_rdata", c), m1_rdata, 32'h00A5_0103);
    end

    // Reset asserted during ACCESS of an m1 write
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h14;
    #4 chk("mid_gnt1", {31'd0, m1_gnt}, 32'd1);
    @(posedge clk);
    #1 drive_idle();
    rst_n = 1'b0;
    #4 chk("mid_access_cs", {28'd0, xbus_cs}, 32'h2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #4;
    chk("mid_after_cs",  {28'd0, xbus_cs}, 32'd0);
    chk("mid_after_rv",  {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("mid_after_xwe", {31'd0, xbus_we}, 32'd0);
    @(posedge clk);
    #1;
    m0_req = 1'b1; m1_req = 1'b1;
    #4;
    chk("mid_tie_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("mid_tie_gnt1", {31'd0, m1_gnt}, 32'd0);
    @(posedge clk);
    #1 drive_idle();
    #4 chk("mid_rv_none", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    @(posedge clk);
    #5 chk("mid_rv0_after", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
